qsfp_i2c_poller: RTL and testbench

QSFP_I2C_POLLER -- requirements
Module: qsfp_i2c_poller

---
 rtl/qsfp_i2c_poller.sv | 188 ++++++++++++++++++
 tb/tb_qsfp_i2c_poller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_i2c_poller.sv
// rtl/qsfp_i2c_poller.sv - reads one QSFP register through an OpenCores-style I2C master over Wishbone
module qsfp_i2c_poller #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter logic [15:0] PRESCALE = 16'd99,
    parameter logic [15:0] POLL_MAX = 16'd65535
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_i,
    input  logic [7:0] req_reg_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [1:0] err_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    output logic       wbm_we_o,
    output logic       wbm_cyc_o,
    output logic       wbm_stb_o,
    input  logic [7:0] wbm_dat_i,
    input  logic       wbm_ack_i
);

    typedef enum logic [3:0] {
        INIT_LO, INIT_HI, INIT_CTR, IDLE, WR_TXR, WR_CR,
        POLL, CHECK, STOP_CR, STOP_POLL, RD_RXR, FINISH
    } state_t;

    state_t      state;
    logic [7:0]  reg_idx;
    logic [7:0]  sr;
    logic [1:0]  phase;
    logic [1:0]  err_code;
    logic [15:0] poll_cnt;
    logic        poll_expired;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_dat;
    logic        acc_we;

    // True on the SR read that uses up the last of the POLL_MAX budget
    assign poll_expired = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_MAX};

    always_comb begin
        acc_adr = 3'd0;
        acc_dat = 8'h00;
        acc_we  = 1'b0;
        case (state)
            INIT_LO:  begin acc_adr = 3'd0; acc_dat = PRESCALE[7:0];  acc_we = 1'b1; end
            INIT_HI:  begin acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; acc_we = 1'b1; end
            INIT_CTR: begin acc_adr = 3'd2; acc_dat = 8'h80;          acc_we = 1'b1; end
            WR_TXR: begin
                acc_adr = 3'd3;
                acc_we  = 1'b1;
                case (phase)
                    2'd0:    acc_dat = {DEV_ADDR, 1'b0};
                    2'd1:    acc_dat = reg_idx;
                    default: acc_dat = {DEV_ADDR, 1'b1};
                endcase
            end
            WR_CR: begin
                acc_adr = 3'd4;
                acc_we  = 1'b1;
                case (phase)
                    2'd1:    acc_dat = 8'h10;
                    2'd3:    acc_dat = 8'h68;
                    default: acc_dat = 8'h90;
                endcase
            end
            POLL, STOP_POLL: acc_adr = 3'd4;
            STOP_CR: begin acc_adr = 3'd4; acc_dat = 8'h40; acc_we = 1'b1; end
            RD_RXR:  acc_adr = 3'd3;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= INIT_LO;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
            rdata_o   <= 8'h00;
            err_o     <= 2'd0;
            wbm_adr_o <= 3'd0;
            wbm_dat_o <= 8'h00;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            reg_idx   <= 8'h00;
            sr        <= 8'h00;
            phase     <= 2'd0;
            err_code  <= 2'd0;
            poll_cnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        reg_idx  <= req_reg_i;
                        busy_o   <= 1'b1;
                        phase    <= 2'd0;
                        err_code <= 2'd0;
                        state    <= WR_TXR;
                    end
                end
                CHECK: begin
                    if (phase == 2'd3) begin
                        state <= RD_RXR;
                    end else if (sr[5]) begin
                        // Arbitration lost: the core has already let go of the bus
                        done_o  <= 1'b1;
                        err_o   <= 2'd2;
                        rdata_o <= 8'h00;
                        state   <= FINISH;
                    end else if (sr[7]) begin
                        err_code <= 2'd1;
                        state    <= STOP_CR;
                    end else begin
                        phase <= phase + 2'd1;
                        state <= (phase == 2'd2) ? WR_CR : WR_TXR;
                    end
                end
                FINISH: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                INIT_LO, INIT_HI, INIT_CTR, WR_TXR, WR_CR, POLL,
                STOP_CR, STOP_POLL, RD_RXR: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_adr_o <= acc_adr;
                        wbm_dat_o <= acc_dat;
                        wbm_we_o  <= acc_we;
                    end else if (wbm_ack_i) begin
                        // Dropping cyc here guarantees an idle cycle before the next strobe
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        case (state)
                            INIT_LO:  state <= INIT_HI;
                            INIT_HI:  state <= INIT_CTR;
                            INIT_CTR: begin busy_o <= 1'b0; state <= IDLE; end
                            WR_TXR:   state <= WR_CR;
                            WR_CR:    begin poll_cnt <= 16'd0; state <= POLL; end
                            POLL: begin
                                if (!wbm_dat_i[1]) begin
                                    sr    <= wbm_dat_i;
                                    state <= CHECK;
                                end else if (poll_expired) begin
                                    err_code <= 2'd3;
                                    state    <= STOP_CR;
                                end else begin
                                    poll_cnt <= poll_cnt + 16'd1;
                                end
                            end
                            STOP_CR: begin poll_cnt <= 16'd0; state <= STOP_POLL; end
                            STOP_POLL: begin
                                if (!wbm_dat_i[1] || poll_expired) begin
                                    done_o  <= 1'b1;
                                    err_o   <= err_code;
                                    rdata_o <= 8'h00;
                                    state   <= FINISH;
                                end else begin
                                    poll_cnt <= poll_cnt + 16'd1;
                                end
                            end
                            RD_RXR: begin
                                done_o  <= 1'b1;
                                err_o   <= 2'd0;
                                rdata_o <= wbm_dat_i;
                                state   <= FINISH;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    busy_o    <= 1'b1;
                    state     <= INIT_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qsfp_i2c_poller.sv
// tb/tb_qsfp_i2c_poller.sv - directed bench with a behavioural I2C core and QSFP slave model
module tb_qsfp_i2c_poller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [7:0] req_reg = 8'h00;
    logic       busy, done;
    logic [7:0] rdata;
    logic [1:0] err;
    logic [2:0] adr;
    logic [7:0] dat_o;
    logic       we, cyc, stb;
    logic [7:0] dat_i = 8'h00;
    logic       ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Model configuration, written only by the stimulus process
    int         tip_n = 2;
    logic [7:0] sr_p1 = 8'h00, sr_p2 = 8'h00, sr_p3 = 8'h00, sr_p4 = 8'h00, sr_stop = 8'h00;
    logic [7:0] rx_val = 8'hA5;

    // Model state, written only by the model process
    logic [7:0]  last_txr = 8'h00;
    logic [7:0]  last_cr = 8'h00;
    int          poll_left = 0;
    int          sr_reads = 0;
    int          sr_at_stop = 0;
    int          done_cnt = 0;
    logic [10:0] wlog[$];

    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    qsfp_i2c_poller #(
        .DEV_ADDR(7'h50),
        .PRESCALE(16'd99),
        .POLL_MAX(16'd16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req_i    (req),
        .req_reg_i(req_reg),
        .busy_o   (busy),
        .done_o   (done),
        .rdata_o  (rdata),
        .err_o    (err),
        .wbm_adr_o(adr),
        .wbm_dat_o(dat_o),
        .wbm_we_o (we),
        .wbm_cyc_o(cyc),
        .wbm_stb_o(stb),
        .wbm_dat_i(dat_i),
        .wbm_ack_i(ack)
    );

    function automatic logic [7:0] sr_sel(input logic [7:0] cr, input logic [7:0] txr);
        case (cr)
            8'h90:   return (txr == 8'hA1) ? sr_p3 : sr_p1;
            8'h10:   return sr_p2;
            8'h68:   return sr_p4;
            8'h40:   return sr_stop;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (stb && !ack) begin
            ack <= 1'b1;
            if (we) begin
                wlog.push_back({adr, dat_o});
                if (adr == 3'd3) last_txr <= dat_o;
                if (adr == 3'd4) begin
                    last_cr   <= dat_o;
                    poll_left <= tip_n;
                    if (dat_o == 8'h40) sr_at_stop <= sr_reads;
                end
            end else if (adr == 3'd4) begin
                sr_reads <= sr_reads + 1;
                if (poll_left > 0) begin
                    dat_i     <= 8'h02;
                    poll_left <= poll_left - 1;
                end else begin
                    dat_i <= sr_sel(last_cr, last_txr);
                end
            end else begin
                dat_i <= rx_val;
            end
        end else begin
            ack <= 1'b0;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int tip, input logic [7:0] p1, input logic [7:0] p3,
                       input logic [7:0] stp, input logic [7:0] rx);
        tip_n   = tip;
        sr_p1   = p1;
        sr_p2   = 8'h00;
        sr_p3   = p3;
        sr_p4   = 8'h00;
        sr_stop = stp;
        rx_val  = rx;
    endtask

    task automatic start_req(input string tag, input logic [7:0] r);
        @(negedge clk);
        req_reg = r;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_vec({tag, "_busy_up"}, busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_vec({tag, "_done"}, done, 1);
    endtask

    task automatic check_log(input string tag, input int base);
        check_vec({tag, "_nwr"}, wlog.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++)
            check_vec($sformatf("%s_wr%0d", tag, i), wlog[base + i], exp_q[i]);
    endtask

    initial begin
        int base;
        int sbase;
        int dbase;
        int n;

        cfg(2, 8'h00, 8'h00, 8'h00, 8'hA5);
        repeat (3) @(negedge clk);
        check_vec("rst_busy", busy, 1);
        check_vec("rst_done", done, 0);
        check_vec("rst_cyc", {cyc, stb, we}, 0);
        check_vec("rst_rdata", rdata, 0);
        check_vec("rst_err", err, 0);

        base = wlog.size();
        rst  = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check_vec("init_idle", busy, 0);
        exp_q = '{11'h063, 11'h100, 11'h280};
        check_log("init", base);

        // Full read, slave acks everything
        base = wlog.size();
        start_req("rd", 8'h16);
        wait_done("rd");
        check_vec("rd_rdata", rdata, 8'hA5);
        check_vec("rd_err", err, 0);
        exp_q = '{11'h3A0, 11'h490, 11'h316, 11'h410, 11'h3A1, 11'h490, 11'h468};
        check_log("rd", base);
        @(negedge clk);
        check_vec("rd_busy_low", {busy, done}, 0);
        check_vec("rd_rdata_hold", rdata, 8'hA5);

        // Address NACK
        cfg(2, 8'h80, 8'h00, 8'h00, 8'hA5);
        base = wlog.size();
        start_req("nack", 8'h16);
        wait_done("nack");
        check_vec("nack_err", err, 1);
        check_vec("nack_rdata", rdata, 0);
        exp_q = '{11'h3A0, 11'h490, 11'h440};
        check_log("nack", base);

        // TIP clears on the last allowed SR read of every phase
        cfg(15, 8'h00, 8'h00, 8'h00, 8'h5A);
        base  = wlog.size();
        sbase = sr_reads;
        start_req("edge", 8'h7E);
        wait_done("edge");
        check_vec("edge_err", err, 0);
        check_vec("edge_rdata", rdata, 8'h5A);
        check_vec("edge_reads", sr_reads - sbase, 64);
        exp_q = '{11'h3A0, 11'h490, 11'h37E, 11'h410, 11'h3A1, 11'h490, 11'h468};
        check_log("edge", base);

        // Arbitration lost after the repeated-start address
        cfg(2, 8'h00, 8'h20, 8'h00, 8'hA5);
        base = wlog.size();
        start_req("al", 8'h16);
        wait_done("al");
        check_vec("al_err", err, 2);
        check_vec("al_rdata", rdata, 0);
        exp_q = '{11'h3A0, 11'h490, 11'h316, 11'h410, 11'h3A1, 11'h490};
        check_log("al", base);

        // TIP stuck: address poll and stop poll both time out
        cfg(1000, 8'h00, 8'h00, 8'h00, 8'hA5);
        base  = wlog.size();
        sbase = sr_reads;
        start_req("tmo", 8'h16);
        wait_done("tmo");
        check_vec("tmo_err", err, 3);
        check_vec("tmo_rdata", rdata, 0);
        check_vec("tmo_reads_p1", sr_at_stop - sbase, 16);
        check_vec("tmo_reads_all", sr_reads - sbase, 32);
        exp_q = '{11'h3A0, 11'h490, 11'h440};
        check_log("tmo", base);

        // Request while busy is dropped
        cfg(2, 8'h00, 8'h00, 8'h00, 8'hC3);
        base = wlog.size();
        start_req("ign", 8'h16);
        repeat (5) @(negedge clk);
        req_reg = 8'h33;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done("ign");
        check_vec("ign_rdata", rdata, 8'hC3);
        repeat (20) @(negedge clk);
        check_vec("ign_idle", busy, 0);
        exp_q = '{11'h3A0, 11'h490, 11'h316, 11'h410, 11'h3A1, 11'h490, 11'h468};
        check_log("ign", base);

        // Request held high restarts right after busy falls
        @(negedge clk);
        req_reg = 8'h16;
        req     = 1'b1;
        wait_done("hold1");
        check_vec("hold_busy_at_done", busy, 1);
        @(negedge clk);
        check_vec("hold_busy_low", busy, 0);
        @(negedge clk);
        check_vec("hold_busy_again", busy, 1);
        req = 1'b0;
        wait_done("hold2");
        check_vec("hold2_rdata", rdata, 8'hC3);
        @(negedge clk);

        // Reset in the middle of the register-index TXR write
        cfg(2, 8'h00, 8'h00, 8'h00, 8'hA5);
        dbase = done_cnt;
        @(negedge clk);
        req_reg = 8'h16;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!(stb && adr == 3'd3 && dat_o == 8'h16) && n < 200) begin @(negedge clk); n++; end
        check_vec("mid_p2_stb", stb, 1);
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid_cyc_stb", {cyc, stb}, 0);
        check_vec("mid_busy", busy, 1);
        check_vec("mid_out", {done, err, rdata}, 0);
        base = wlog.size();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check_vec("mid_idle", busy, 0);
        exp_q = '{11'h063, 11'h100, 11'h280};
        check_log("mid_init", base);
        repeat (5) @(negedge clk);
        check_vec("mid_no_done", done_cnt - dbase, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
